playbus_ram_responder: RTL and testbench

//  Bus-side responder for the PlayBus 16x8 RAM: the target end of the n_RAMO/n_RAMW strobes that the bus controller drives.

---
 rtl/playbus_pkg.sv | 21 ++
 rtl/playbus_strobe_filter.sv | 56 +++++
 rtl/playbus_ram_responder.sv | 172 +++++++++++++++++
 tb/tb_playbus_ram_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/playbus_pkg.sv
// Shared types and constants for the PlayBus RAM responder slice.
package playbus_pkg;

  localparam int unsigned PB_ADDR_W = 4;
  localparam int unsigned PB_DATA_W = 8;

  // Bus controller function codes
  localparam logic [2:0] FUNC_ROM_READ  = 3'd0;
  localparam logic [2:0] FUNC_RAM_READ  = 3'd1;
  localparam logic [2:0] FUNC_SWITCHES  = 3'd2;
  localparam logic [2:0] FUNC_SW_TO_LED = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WR_ARM    = 3'd2,
    WR_COMMIT = 3'd3,
    FAULT     = 3'd4
  } resp_state_t;

endpackage

// File: rtl/playbus_strobe_filter.sv
// Synchronises one active-low strobe and accepts a new level only after it
// has been stable for MIN_PULSE local clock cycles.
module playbus_strobe_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_PULSE   = 2
) (
  input  logic CLK,
  input  logic n_CLR,
  input  logic d_n,
  output logic q_n
);

  localparam int unsigned CntW = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MIN_PULSE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   q_n_q, q_n_d;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge n_CLR) begin
    if (!n_CLR) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_n};
    end
  end

  // Counter runs only while the synchronised level differs from the output.
  always_comb begin
    cnt_d = '0;
    q_n_d = q_n_q;
    if (sync_lvl != q_n_q) begin
      if (cnt_q == CntMax) begin
        q_n_d = sync_lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge n_CLR) begin
    if (!n_CLR) begin
      cnt_q <= '0;
      q_n_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      q_n_q <= q_n_d;
    end
  end

  assign q_n = q_n_q;

endmodule

// File: rtl/playbus_ram_responder.sv
// Target side of the PlayBus 16x8 RAM: filters the strobes, serves reads and commits writes.
// Optional ERR_COUNT output when PLAYBUS_RESP_ERRCNT_EN is defined.
module playbus_ram_responder
  import playbus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_PULSE   = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 CLK,
  input  logic                 n_CLR,
  input  logic [PB_ADDR_W-1:0] ADD,
  input  logic [PB_DATA_W-1:0] DATA_IN,
  input  logic                 n_RAMO,
  input  logic                 n_RAMW,
  input  logic                 n_ROMO,
  input  logic                 n_SWBEN,
  output logic [PB_DATA_W-1:0] DATA_OUT,
  output logic                 DATA_OE,
  output logic                 BUSY,
  output logic                 ERR,
`ifdef PLAYBUS_RESP_ERRCNT_EN
  output logic [7:0]           ERR_COUNT,
`endif
  output logic [CNT_W-1:0]     WR_COUNT
);

  localparam int unsigned Words = 1 << PB_ADDR_W;

  logic ramo_n_f, ramw_n_f, romo_n_f, swben_n_f;
  logic r_o, r_w, rom_o, sw_o;
  logic contention;
  logic commit;

  resp_state_t state_q, state_d;

  logic [PB_DATA_W-1:0] mem_q [Words];
  logic [PB_DATA_W-1:0] data_out_q;
  logic [PB_ADDR_W-1:0] a_lat_q;
  logic [PB_DATA_W-1:0] d_lat_q;
  logic [CNT_W-1:0]     wr_count_q;
  logic                 err_q;

  playbus_strobe_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_PULSE  (MIN_PULSE)
  ) u_filt_ramo (
    .CLK  (CLK),
    .n_CLR(n_CLR),
    .d_n  (n_RAMO),
    .q_n  (ramo_n_f)
  );

  playbus_strobe_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_PULSE  (MIN_PULSE)
  ) u_filt_ramw (
    .CLK  (CLK),
    .n_CLR(n_CLR),
    .d_n  (n_RAMW),
    .q_n  (ramw_n_f)
  );

  playbus_strobe_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_PULSE  (MIN_PULSE)
  ) u_filt_romo (
    .CLK  (CLK),
    .n_CLR(n_CLR),
    .d_n  (n_ROMO),
    .q_n  (romo_n_f)
  );

  playbus_strobe_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_PULSE  (MIN_PULSE)
  ) u_filt_swben (
    .CLK  (CLK),
    .n_CLR(n_CLR),
    .d_n  (n_SWBEN),
    .q_n  (swben_n_f)
  );

  assign r_o   = ~ramo_n_f;
  assign r_w   = ~ramw_n_f;
  assign rom_o = ~romo_n_f;
  assign sw_o  = ~swben_n_f;

  // Two data sources driving at once, or a read and write strobe together.
  assign contention = (r_o & rom_o) | (r_o & sw_o) | (rom_o & sw_o) | (r_o & r_w);

  always_comb begin
    state_d = state_q;
    if (contention) begin
      state_d = FAULT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (r_w) begin
            state_d = WR_ARM;
          end else if (r_o) begin
            state_d = READ;
          end
        end
        READ: begin
          if (!r_o) state_d = IDLE;
        end
        WR_ARM: begin
          if (!r_w) state_d = WR_COMMIT;
        end
        WR_COMMIT: state_d = IDLE;
        FAULT: begin
          if (!(r_o | r_w | rom_o | sw_o)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A commit is skipped when contention diverts WR_COMMIT into FAULT.
  assign commit = (state_q == WR_COMMIT) && (state_d == IDLE);

  always_ff @(posedge CLK or negedge n_CLR) begin
    if (!n_CLR) begin
      state_q    <= IDLE;
      data_out_q <= '0;
      a_lat_q    <= '0;
      d_lat_q    <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      state_q <= state_d;
      // Loading on entry makes valid data coincide with DATA_OE rising.
      if (state_d == READ) begin
        data_out_q <= mem_q[ADD];
      end
      if (state_q == WR_ARM) begin
        a_lat_q <= ADD;
        d_lat_q <= DATA_IN;
      end
      if (commit) begin
        mem_q[a_lat_q] <= d_lat_q;
        wr_count_q     <= wr_count_q + 1'b1;
      end
      if (state_d == FAULT) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef PLAYBUS_RESP_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge CLK or negedge n_CLR) begin
    if (!n_CLR) begin
      err_cnt_q <= '0;
    end else if ((state_d == FAULT) && (state_q != FAULT) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign ERR_COUNT = err_cnt_q;
`endif

  assign DATA_OUT = data_out_q;
  assign DATA_OE  = (state_q == READ);
  assign BUSY     = (state_q == READ) || (state_q == WR_ARM) || (state_q == WR_COMMIT);
  assign ERR      = err_q;
  assign WR_COUNT = wr_count_q;

endmodule

// File: tb/tb_playbus_ram_responder.sv
// Directed self-checking bench for playbus_ram_responder.
module tb_playbus_ram_responder;

  logic       CLK = 1'b0;
  logic       n_CLR;
  logic [3:0] ADD;
  logic [7:0] DATA_IN;
  logic       n_RAMO, n_RAMW, n_ROMO, n_SWBEN;
  logic [7:0] DATA_OUT;
  logic       DATA_OE, BUSY, ERR;
  logic [7:0] WR_COUNT;
`ifdef PLAYBUS_RESP_ERRCNT_EN
  logic [7:0] ERR_COUNT;
`endif

  int vectors = 0;
  int miscompares = 0;

  playbus_ram_responder #(
    .SYNC_STAGES(2),
    .MIN_PULSE  (2),
    .CNT_W      (8)
  ) dut (
    .CLK      (CLK),
    .n_CLR    (n_CLR),
    .ADD      (ADD),
    .DATA_IN  (DATA_IN),
    .n_RAMO   (n_RAMO),
    .n_RAMW   (n_RAMW),
    .n_ROMO   (n_ROMO),
    .n_SWBEN  (n_SWBEN),
    .DATA_OUT (DATA_OUT),
    .DATA_OE  (DATA_OE),
    .BUSY     (BUSY),
    .ERR      (ERR),
`ifdef PLAYBUS_RESP_ERRCNT_EN
    .ERR_COUNT(ERR_COUNT),
`endif
    .WR_COUNT (WR_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int low);
    ADD = a; DATA_IN = d; n_RAMW = 1'b0;
    cycles(low);
    n_RAMW = 1'b1;
    cycles(8);
  endtask

  task automatic do_read(input logic [3:0] a, output logic [7:0] d);
    ADD = a; n_RAMO = 1'b0;
    cycles(8);
    d = DATA_OUT;
    n_RAMO = 1'b1;
    cycles(8);
  endtask

  task automatic test_reset;
    n_CLR = 1'b0; ADD = '0; DATA_IN = '0;
    n_RAMO = 1'b1; n_RAMW = 1'b1; n_ROMO = 1'b1; n_SWBEN = 1'b1;
    cycles(2);
    vectors++; if (DATA_OE !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %b exp 0", DATA_OE); end
    vectors++; if (DATA_OUT !== 8'h00) begin miscompares++; $display("FAIL reset_dout got %h exp 00", DATA_OUT); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", ERR); end
    vectors++; if (WR_COUNT !== 8'd0) begin miscompares++; $display("FAIL reset_wrcnt got %0d exp 0", WR_COUNT); end
    n_CLR = 1'b1;
    cycles(2);
  endtask

  task automatic test_first_read;
    int waited = 0;
    ADD = 4'd3; n_RAMO = 1'b0;
    while (DATA_OE !== 1'b1 && waited < 5) begin
      cycles(1);
      waited++;
    end
    vectors++; if (DATA_OE !== 1'b1) begin miscompares++; $display("FAIL first_read_oe got %b exp 1 within 5 clk", DATA_OE); end
    vectors++; if (DATA_OUT !== 8'h00) begin miscompares++; $display("FAIL first_read_data got %h exp 00", DATA_OUT); end
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL first_read_busy got %b exp 1", BUSY); end
    vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL first_read_err got %b exp 0", ERR); end
    n_RAMO = 1'b1;
    cycles(8);
    vectors++; if (DATA_OE !== 1'b0) begin miscompares++; $display("FAIL read_release_oe got %b exp 0", DATA_OE); end
  endtask

  task automatic test_write_read;
    do_write(4'd7, 8'h5A, 20);
    vectors++; if (WR_COUNT !== 8'd1) begin miscompares++; $display("FAIL write_count got %0d exp 1", WR_COUNT); end
    ADD = 4'd7; n_RAMO = 1'b0;
    cycles(8);
    vectors++; if (DATA_OUT !== 8'h5A) begin miscompares++; $display("FAIL read7 got %h exp 5a", DATA_OUT); end
    ADD = 4'd3;
    cycles(1);
    vectors++; if (DATA_OUT !== 8'h00) begin miscompares++; $display("FAIL track_add3 got %h exp 00", DATA_OUT); end
    ADD = 4'd7;
    cycles(1);
    vectors++; if (DATA_OUT !== 8'h5A) begin miscompares++; $display("FAIL track_add7 got %h exp 5a", DATA_OUT); end
    n_RAMO = 1'b1;
    cycles(8);
  endtask

  task automatic test_last_data;
    logic [7:0] d;
    ADD = 4'd5; DATA_IN = 8'h11; n_RAMW = 1'b0;
    cycles(10);
    DATA_IN = 8'h22;
    cycles(10);
    n_RAMW = 1'b1;
    cycles(8);
    do_read(4'd5, d);
    vectors++; if (d !== 8'h22) begin miscompares++; $display("FAIL last_data got %h exp 22", d); end
    vectors++; if (WR_COUNT !== 8'd2) begin miscompares++; $display("FAIL last_data_count got %0d exp 2", WR_COUNT); end
  endtask

  task automatic test_contention;
    logic [7:0] d;
    ADD = 4'd2; n_RAMO = 1'b0; n_SWBEN = 1'b0;
    cycles(6);
    vectors++; if (DATA_OE !== 1'b0) begin miscompares++; $display("FAIL fault_oe got %b exp 0", DATA_OE); end
    vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL fault_err got %b exp 1", ERR); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL fault_busy got %b exp 0", BUSY); end
    n_RAMO = 1'b1; n_SWBEN = 1'b1;
    cycles(8);
    vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b exp 1", ERR); end
    ADD = 4'd5; DATA_IN = 8'hEE;
    n_RAMO = 1'b0; n_SWBEN = 1'b0; n_RAMW = 1'b0;
    cycles(10);
    n_RAMO = 1'b1; n_SWBEN = 1'b1; n_RAMW = 1'b1;
    cycles(8);
    vectors++; if (WR_COUNT !== 8'd2) begin miscompares++; $display("FAIL fault_wr_dropped got %0d exp 2", WR_COUNT); end
    do_read(4'd5, d);
    vectors++; if (d !== 8'h22) begin miscompares++; $display("FAIL fault_mem_kept got %h exp 22", d); end
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    ADD = 4'd1; DATA_IN = 8'h99; n_RAMW = 1'b0;
    cycles(1);
    n_RAMW = 1'b1;
    cycles(8);
    vectors++; if (WR_COUNT !== 8'd2) begin miscompares++; $display("FAIL glitch_count got %0d exp 2", WR_COUNT); end
    do_read(4'd1, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL glitch_mem got %h exp 00", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    ADD = 4'hA; DATA_IN = 8'h3C; n_RAMW = 1'b0;
    cycles(8);
    n_RAMW = 1'b1;
    cycles(2);
    n_RAMW = 1'b0;
    cycles(4);
    ADD = 4'hB; DATA_IN = 8'hC3;
    cycles(6);
    n_RAMW = 1'b1;
    cycles(8);
    vectors++; if (WR_COUNT !== 8'd4) begin miscompares++; $display("FAIL b2b_count got %0d exp 4", WR_COUNT); end
    do_read(4'hA, d);
    vectors++; if (d !== 8'h3C) begin miscompares++; $display("FAIL b2b_first got %h exp 3c", d); end
    do_read(4'hB, d);
    vectors++; if (d !== 8'hC3) begin miscompares++; $display("FAIL b2b_second got %h exp c3", d); end
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] d;
    ADD = 4'd9; DATA_IN = 8'h77; n_RAMW = 1'b0;
    cycles(10);
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL arm_busy got %b exp 1", BUSY); end
    n_CLR = 1'b0;
    cycles(1);
    vectors++; if (DATA_OUT !== 8'h00) begin miscompares++; $display("FAIL midrst_dout got %h exp 00", DATA_OUT); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b exp 0", BUSY); end
    vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL midrst_err got %b exp 0", ERR); end
    vectors++; if (WR_COUNT !== 8'd0) begin miscompares++; $display("FAIL midrst_count got %0d exp 0", WR_COUNT); end
    n_RAMW = 1'b1;
    cycles(1);
    n_CLR = 1'b1;
    cycles(4);
    do_read(4'd9, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL midrst_mem9 got %h exp 00", d); end
    do_read(4'd7, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL midrst_mem7 got %h exp 00", d); end
    vectors++; if (WR_COUNT !== 8'd0) begin miscompares++; $display("FAIL midrst_count_after got %0d exp 0", WR_COUNT); end
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    for (int i = 0; i < 255; i++) begin
      do_write(4'(i), 8'(i), 3);
    end
    vectors++; if (WR_COUNT !== 8'hFF) begin miscompares++; $display("FAIL wrap_allones got %0d exp 255", WR_COUNT); end
    do_write(4'hF, 8'hFF, 3);
    vectors++; if (WR_COUNT !== 8'h00) begin miscompares++; $display("FAIL wrap_zero got %0d exp 0", WR_COUNT); end
    do_read(4'hF, d);
    vectors++; if (d !== 8'hFF) begin miscompares++; $display("FAIL wrap_memF got %h exp ff", d); end
    do_read(4'h0, d);
    vectors++; if (d !== 8'hF0) begin miscompares++; $display("FAIL wrap_mem0 got %h exp f0", d); end
  endtask

`ifdef PLAYBUS_RESP_ERRCNT_EN
  task automatic test_errcnt;
    vectors++; if (ERR_COUNT !== 8'd0) begin miscompares++; $display("FAIL errcnt_start got %0d exp 0", ERR_COUNT); end
    for (int i = 0; i < 3; i++) begin
      n_ROMO = 1'b0; n_SWBEN = 1'b0;
      cycles(6);
      n_ROMO = 1'b1; n_SWBEN = 1'b1;
      cycles(8);
    end
    vectors++; if (ERR_COUNT !== 8'd3) begin miscompares++; $display("FAIL errcnt_three got %0d exp 3", ERR_COUNT); end
    vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL errcnt_err got %b exp 1", ERR); end
  endtask
`endif

  initial begin
    test_reset;
    test_first_read;
    test_write_read;
    test_last_data;
    test_contention;
    test_glitch;
    test_back_to_back;
    test_reset_mid_write;
    test_wrap;
`ifdef PLAYBUS_RESP_ERRCNT_EN
    test_errcnt;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
